tdm_demux8: RTL and testbench
=============================

Name: tdm_demux8

Overview:
- Time-division demultiplexer: receives one serial stream of time-slotted samples (slot 0..7) and distributes each sample to its own channel register.
- Counterpart of the 8-to-1 combinational mux. The mux sequences 8 inputs onto one line; this block recovers the 8 channels at the far end.
- Tracks frame alignment, presents a complete 8-channel frame atomically, and flags sync errors.

Parameters:
- WIDTH, 1, bits per sample/channel
- NUM_CH, 8, channels per frame; fixed at 8, not overridable (slot index is 3 bits)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- din  input  WIDTH  serial sample for the current slot
- din_valid  input  1  din carries a sample this cycle
- frame_sync  input  1  qualified by din_valid; marks the slot-0 sample
- dout  output  8*WIDTH  last complete frame; channel k at dout[k*WIDTH +: WIDTH]
- frame_valid  output  1  one-cycle pulse: dout just updated
- slot  output  3  slot index expected for the next sample
- locked  output  1  high in LOCKED state
- sync_err  output  1  one-cycle pulse on alignment error

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: dout=0, frame_valid=0, slot=0, locked=0, sync_err=0, shadow registers=0, state=HUNT.
- Samples are accepted only when din_valid=1. With din_valid=0, all state holds and pulses deassert.
- HUNT:
  - Discard samples while frame_sync=0.
  - din_valid&frame_sync: write din to shadow[0], slot<=1, state<=LOCKED.
- LOCKED:
  - Each accepted sample is written to shadow[slot], then slot<=slot+1, wrapping 7->0.
  - Sample accepted at slot 7: on the same edge, dout<={din, shadow[6..0]}, frame_valid=1 for the following cycle, slot<=0. Latency: the last sample is visible on dout one cycle after acceptance.
  - frame_sync=1 at slot!=0: sync_err pulse; partial frame discarded (dout unchanged); sample taken as slot 0; slot<=1; stay LOCKED.
  - frame_sync=0 at slot==0: sync_err pulse; sample dropped; state<=HUNT, slot<=0.
- dout only ever changes as a whole frame. No partial update is ever visible.
- Reset mid-frame: partial frame lost, dout cleared, returns to HUNT.
- Back-to-back frames with din_valid continuously high are sustained at full rate (1 sample/cycle).

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN.
- Defined:
  - Frame is 9 slots; slot 8 carries WIDTH-bit even parity, the XOR of all 8 channel samples.
  - slot counts 0..8 and is widened to 4 bits.
  - On slot 8: if parity matches, dout updates and frame_valid pulses. If not, dout holds and output parity_err (1 bit, one-cycle pulse) asserts.
  - sync rules apply with slot 8 as the last slot.
- Undefined: 8-slot frame as above; no parity_err port.

Decomposition:
- Package tdm_pkg:
  - NUM_CH=8, SLOT_W=3 (4 with parity)
  - state enum {HUNT, LOCKED}
  - parity slot index constant
- Sub-module demux1to8: combinational 3-bit slot plus enable to one-hot 8-bit write-enable for the shadow registers.
- Top keeps FSM, counter, shadow, output registers.

Test Plan (WIDTH=4):
- Reset, then frame_sync on the first sample, slots 0..7 = 0x1..0x8 back-to-back -> one cycle after the last sample, frame_valid=1, dout=0x87654321, locked=1, slot=0.
- Same frame with din_valid low for 3 cycles between slots 3 and 4 -> identical dout, frame_valid delayed 3 cycles, no sync_err.
- 5 samples with frame_sync=0 from reset -> locked=0, no frame_valid. Then a full valid frame -> locks, correct dout.
- Locked, frame_sync asserted at slot 5 -> sync_err pulse, dout unchanged. The next 7 samples complete a frame starting at the resync sample, dout matches.
- Locked, frame_sync=0 at slot 0 -> sync_err pulse, locked=0, slot=0. rst asserted at slot 4 of a frame -> next cycle dout=0, locked=0.
- With TDM_DEMUX_PARITY_EN: frame 0x1..0x8 then parity 0x8 -> frame_valid. Parity 0x9 -> parity_err, dout holds its previous value.

Source files
------------

// File: rtl/tdm_demux8_pkg.sv
// Shared constants and types for the tdm_demux8 time-division demultiplexer.
// Build option: TDM_DEMUX_PARITY_EN adds a ninth, even-parity slot to every frame.
package tdm_pkg;

    localparam int NUM_CH = 8;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int SLOT_W    = 4;
    localparam int NUM_SLOTS = 9;
`else
    localparam int SLOT_W    = 3;
    localparam int NUM_SLOTS = 8;
`endif

    localparam logic [SLOT_W-1:0] SLOT_ZERO   = {SLOT_W{1'b0}};
    localparam logic [SLOT_W-1:0] SLOT_ONE    = {{(SLOT_W-1){1'b0}}, 1'b1};
    localparam logic [SLOT_W-1:0] LAST_SLOT   = SLOT_W'(NUM_SLOTS - 1);
    // Only meaningful with the parity slot; equals LAST_SLOT in that build.
    localparam logic [3:0]        PARITY_SLOT = 4'd8;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_demux8_demux1to8.sv
// Slot index plus enable decoded to a one-hot write strobe for the shadow registers.
module demux1to8 (
    input  logic [2:0] sel,
    input  logic       en,
    output logic [7:0] onehot
);

    // One strobe bit per channel; all low when not writing.
    always_comb begin
        onehot = 8'd0;
        if (en) begin
            onehot[sel] = 1'b1;
        end else begin
            onehot = 8'd0;
        end
    end

endmodule

// File: rtl/tdm_demux8.sv
// Time-division demultiplexer: recovers 8 channels from one slotted serial stream.
// Build option: TDM_DEMUX_PARITY_EN (9-slot frames with parity check and parity_err).
module tdm_demux8
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        din,
    input  logic                    din_valid,
    input  logic                    frame_sync,
    output logic [NUM_CH*WIDTH-1:0] dout,
    output logic                    frame_valid,
    output logic [SLOT_W-1:0]       slot,
    output logic                    locked,
    output logic                    sync_err
`ifdef TDM_DEMUX_PARITY_EN
    ,
    output logic                    parity_err
`endif
);

    state_t                         state_r;
    state_t                         state_nxt_s;
    logic [SLOT_W-1:0]              slot_nxt_s;
    logic [NUM_CH-1:0][WIDTH-1:0]   shadow_r;
    logic [NUM_CH-1:0][WIDTH-1:0]   shadow_wr_s;
    logic                           shadow_we_s;
    logic [2:0]                     shadow_sel_s;
    logic [NUM_CH-1:0]              shadow_en_s;
    logic                           load_s;
    logic                           sync_err_s;
`ifdef TDM_DEMUX_PARITY_EN
    logic                           parity_err_s;

    function automatic logic [WIDTH-1:0] frame_parity(input logic [NUM_CH-1:0][WIDTH-1:0] f);
        logic [WIDTH-1:0] p;
        p = {WIDTH{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            p = p ^ f[k];
        end
        return p;
    endfunction
`endif

    demux1to8 u_wr_decode (
        .sel    (shadow_sel_s),
        .en     (shadow_we_s),
        .onehot (shadow_en_s)
    );

    // Shadow contents as they will be after this edge; dout loads from this view so
    // the final sample lands in the frame on the same edge it is accepted.
    always_comb begin
        shadow_wr_s = shadow_r;
        for (int k = 0; k < NUM_CH; k++) begin
            if (shadow_en_s[k]) begin
                shadow_wr_s[k] = din;
            end else begin
                shadow_wr_s[k] = shadow_r[k];
            end
        end
    end

    // Alignment FSM: next state, slot counter and per-sample control.
    always_comb begin
        state_nxt_s  = state_r;
        slot_nxt_s   = slot;
        shadow_we_s  = 1'b0;
        shadow_sel_s = slot[2:0];
        load_s       = 1'b0;
        sync_err_s   = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        parity_err_s = 1'b0;
`endif
        if (din_valid) begin
            case (state_r)
                HUNT: begin
                    if (frame_sync) begin
                        shadow_we_s  = 1'b1;
                        shadow_sel_s = 3'd0;
                        slot_nxt_s   = SLOT_ONE;
                        state_nxt_s  = LOCKED;
                    end else begin
                        slot_nxt_s   = SLOT_ZERO;
                    end
                end
                LOCKED: begin
                    if (frame_sync && (slot != SLOT_ZERO)) begin
                        // Early sync: drop the partial frame, restart on this sample.
                        sync_err_s   = 1'b1;
                        shadow_we_s  = 1'b1;
                        shadow_sel_s = 3'd0;
                        slot_nxt_s   = SLOT_ONE;
                    end else if (!frame_sync && (slot == SLOT_ZERO)) begin
                        sync_err_s   = 1'b1;
                        slot_nxt_s   = SLOT_ZERO;
                        state_nxt_s  = HUNT;
                    end else if (slot == LAST_SLOT) begin
                        slot_nxt_s   = SLOT_ZERO;
`ifdef TDM_DEMUX_PARITY_EN
                        if (frame_parity(shadow_wr_s) == din) begin
                            load_s       = 1'b1;
                        end else begin
                            parity_err_s = 1'b1;
                        end
`else
                        shadow_we_s  = 1'b1;
                        load_s       = 1'b1;
`endif
                    end else begin
                        shadow_we_s  = 1'b1;
                        slot_nxt_s   = slot + SLOT_ONE;
                    end
                end
                default: begin
                    state_nxt_s = HUNT;
                    slot_nxt_s  = SLOT_ZERO;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, counter, shadow and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= HUNT;
            slot        <= SLOT_ZERO;
            shadow_r    <= {(NUM_CH*WIDTH){1'b0}};
            dout        <= {(NUM_CH*WIDTH){1'b0}};
            frame_valid <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            state_r     <= state_nxt_s;
            slot        <= slot_nxt_s;
            shadow_r    <= shadow_wr_s;
            frame_valid <= load_s;
            locked      <= (state_nxt_s == LOCKED);
            sync_err    <= sync_err_s;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err  <= parity_err_s;
`endif
            if (load_s) begin
                dout <= shadow_wr_s;
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed self-checking bench for tdm_demux8 with WIDTH=4.
module tb_tdm_demux8;

    localparam int W = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [W-1:0]              din;
    logic                      din_valid;
    logic                      frame_sync;
    logic [8*W-1:0]            dout;
    logic                      frame_valid;
    logic [tdm_pkg::SLOT_W-1:0] slot;
    logic                      locked;
    logic                      sync_err;
`ifdef TDM_DEMUX_PARITY_EN
    logic                      parity_err;
`endif

    int errors = 0;
    int checks = 0;

    logic [W-1:0] fa [8];
    logic [W-1:0] fb [8];
    logic [W-1:0] fc [8];

    always #5 clk = ~clk;

    tdm_demux8 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .dout        (dout),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err)
`ifdef TDM_DEMUX_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; return just after the rising edge.
    task automatic step(input logic v, input logic s, input logic [W-1:0] d);
        @(negedge clk);
        din_valid  = v;
        frame_sync = s;
        din        = d;
        @(posedge clk);
        #1;
    endtask

    // Send samples first..7 (sync on slot 0 if requested), plus parity when built in.
    task automatic run_frame(input logic [W-1:0] d [8], input logic sync0, input int first,
                             input logic [31:0] exp);
        logic [W-1:0] par;
        par = {W{1'b0}};
        for (int i = 0; i < 8; i++) par = par ^ d[i];
        for (int i = first; i < 8; i++) begin
            step(1'b1, sync0 && (i == 0), d[i]);
            if (i < 7) begin
                check("mid_fv", {31'd0, frame_valid}, 32'd0);
                check("mid_serr", {31'd0, sync_err}, 32'd0);
            end
        end
`ifdef TDM_DEMUX_PARITY_EN
        check("pre_par_fv", {31'd0, frame_valid}, 32'd0);
        step(1'b1, 1'b0, par);
        check("par_ok_err", {31'd0, parity_err}, 32'd0);
`endif
        check("fv", {31'd0, frame_valid}, 32'd1);
        check("dout", dout, exp);
        check("slot_wrap", 32'(slot), 32'd0);
        check("lock", {31'd0, locked}, 32'd1);
        check("serr", {31'd0, sync_err}, 32'd0);
    endtask

    initial begin
        fa = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
        fb = '{4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
        fc = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h3};
        rst = 1'b1;
        step(1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 4'h0);
        check("rst_dout", dout, 32'd0);
        check("rst_fv", {31'd0, frame_valid}, 32'd0);
        check("rst_slot", 32'(slot), 32'd0);
        check("rst_lock", {31'd0, locked}, 32'd0);
        check("rst_serr", {31'd0, sync_err}, 32'd0);
        rst = 1'b0;

        // Back-to-back frame locking on the first sample.
        step(1'b1, 1'b1, fa[0]);
        check("lock_first", {31'd0, locked}, 32'd1);
        check("slot_first", 32'(slot), 32'd1);
        run_frame(fa, 1'b1, 1, 32'h87654321);
        step(1'b0, 1'b0, 4'h0);
        check("fv_pulse_end", {31'd0, frame_valid}, 32'd0);

        // Same frame with a 3-cycle gap; frame_sync while invalid must be ignored.
        for (int i = 0; i < 4; i++) step(1'b1, i == 0, fa[i]);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 4'hF);
            check("gap_slot", 32'(slot), 32'd4);
            check("gap_fv", {31'd0, frame_valid}, 32'd0);
            check("gap_serr", {31'd0, sync_err}, 32'd0);
        end
        run_frame(fa, 1'b1, 4, 32'h87654321);

        // Unsynced samples from reset are discarded.
        rst = 1'b1;
        step(1'b0, 1'b0, 4'h0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 4'hF);
            check("hunt_lock", {31'd0, locked}, 32'd0);
            check("hunt_fv", {31'd0, frame_valid}, 32'd0);
            check("hunt_slot", 32'(slot), 32'd0);
        end
        run_frame(fb, 1'b1, 0, 32'h12345678);

        // Early frame_sync at slot 5 restarts the frame.
        for (int i = 0; i < 5; i++) step(1'b1, i == 0, fa[i]);
        check("pre_resync_slot", 32'(slot), 32'd5);
        step(1'b1, 1'b1, fc[0]);
        check("resync_serr", {31'd0, sync_err}, 32'd1);
        check("resync_dout", dout, 32'h12345678);
        check("resync_fv", {31'd0, frame_valid}, 32'd0);
        check("resync_slot", 32'(slot), 32'd1);
        check("resync_lock", {31'd0, locked}, 32'd1);
        run_frame(fc, 1'b1, 1, 32'h3FEDCBA9);

        // Missing frame_sync at slot 0 drops lock.
        step(1'b1, 1'b0, 4'h5);
        check("nosync_serr", {31'd0, sync_err}, 32'd1);
        check("nosync_lock", {31'd0, locked}, 32'd0);
        check("nosync_slot", 32'(slot), 32'd0);
        check("nosync_dout", dout, 32'h3FEDCBA9);
        step(1'b0, 1'b0, 4'h0);
        check("serr_pulse_end", {31'd0, sync_err}, 32'd0);

        // Reset in the middle of a frame.
        for (int i = 0; i < 4; i++) step(1'b1, i == 0, fa[i]);
        check("mid_slot4", 32'(slot), 32'd4);
        rst = 1'b1;
        step(1'b1, 1'b0, fa[4]);
        rst = 1'b0;
        check("midrst_dout", dout, 32'd0);
        check("midrst_lock", {31'd0, locked}, 32'd0);
        check("midrst_slot", 32'(slot), 32'd0);
        check("midrst_fv", {31'd0, frame_valid}, 32'd0);

`ifdef TDM_DEMUX_PARITY_EN
        // Good parity (0x8) accepted, then bad parity (0x9) rejected.
        run_frame(fa, 1'b1, 0, 32'h87654321);
        for (int i = 0; i < 8; i++) step(1'b1, i == 0, fa[i]);
        step(1'b1, 1'b0, 4'h9);
        check("bad_par_err", {31'd0, parity_err}, 32'd1);
        check("bad_par_fv", {31'd0, frame_valid}, 32'd0);
        check("bad_par_dout", dout, 32'h87654321);
        check("bad_par_slot", 32'(slot), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
